seven_segment_display_decoder: RTL
==================================

SEVEN_SEGMENT_DISPLAY_DECODER -- requirements
Module: seven_segment_display_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive cycles the synchronized anode/cathode inputs SHALL be unchanged before a digit is captured.
REQ-002 clock_100Mhz  input  1  system clock; reset  input  1  reset, asynchronous, active-high.
REQ-003 Anode_Activate  input  4  active-low digit enables; bit3 = thousands digit, bit0 = units digit.
REQ-004 LED_out  input  7  active-low cathodes, bit6 = segment a … bit0 = segment g.
REQ-005 decoded_number  output  16  binary value 0..9999 of the last complete frame.
REQ-006 decoded_bcd  output  16  BCD of the last complete frame, [15:12] = thousands.
REQ-007 frame_valid  output  1  single-cycle pulse when decoded_number/decoded_bcd update.
REQ-008 pattern_error  output  1  single-cycle pulse on a settled, unrecognized cathode pattern.
REQ-009 anode_error  output  1  single-cycle pulse on a settled anode word with more than one bit low.
REQ-010 digits_seen  output  4  digits captured in the current, incomplete frame; bit order matches Anode_Activate, active-high.

Function
REQ-011 Anode_Activate and LED_out SHALL pass through a 2-flop synchronizer; all later logic SHALL use only synchronized values.
REQ-012 Stability counter: reset to 0 on any change of the synchronized 11-bit {anode, cathode}; otherwise increment, saturating at SETTLE_CYCLES.
REQ-013 Capture strobe SHALL fire exactly once per stable period, in the cycle the counter first reaches SETTLE_CYCLES.
REQ-014 At capture, anode 4'b1111 (blank) SHALL be ignored silently.
REQ-015 At capture, an anode with two or more bits low SHALL pulse anode_error and be ignored.
REQ-016 Cathode decode, active-low: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
REQ-017 If the anode is one-hot-low and the cathode is not in the REQ-016 table, capture SHALL pulse pattern_error and leave the digit register and digits_seen unchanged.
REQ-018 If the anode is one-hot-low and the cathode is valid, capture SHALL write the digit register for that position and set its digits_seen bit; a repeated position overwrites the previous value.
REQ-019 When digits_seen becomes 4'b1111, the next cycle SHALL do all of the following: clear digits_seen; load decoded_bcd; load decoded_number = d3*1000 + d2*100 + d1*10 + d0 (17-bit intermediate, no overflow for 9999); pulse frame_valid.
REQ-020 Latency: frame_valid SHALL assert exactly SETTLE_CYCLES+3 clock edges after the final digit's inputs become stable at the module pins.
REQ-021 decoded_number and decoded_bcd SHALL hold their value between frames.
REQ-022 A capture landing in the same cycle as the frame-completion load SHALL count toward the new frame.
REQ-023 All error and valid pulses SHALL be exactly one cycle wide.

Reset
REQ-024 Reset SHALL force the following to zero: decoded_number, decoded_bcd, frame_valid, pattern_error, anode_error, digits_seen, digit registers, stability counter and synchronizer flops.
REQ-025 Reset asserted mid-frame SHALL discard any partially captured digits; after release, all four digits SHALL be captured again before frame_valid.

Structure
REQ-026 Shared package seven_seg_pkg SHALL hold the ten cathode pattern constants, the four one-hot-low anode constants, the blank anode constant and the SETTLE_CYCLES default.
REQ-027 The combinational sub-module seven_seg_pattern_decoder SHALL map 7-bit cathodes to a 4-bit digit plus a valid flag; the top SHALL instantiate it once.

Verification
REQ-028 Scan 1,2,3,4 across anodes 0111/1011/1101/1110, 64 cycles each -> one frame_valid pulse, decoded_number = 16'h04D2, decoded_bcd = 16'h1234.
REQ-029 Hold one digit for SETTLE_CYCLES-1 cycles, then change it -> no capture, digits_seen unchanged; hold for SETTLE_CYCLES cycles -> digit captured.
REQ-030 Cathode 7'b1111111 on the hundreds digit -> one pattern_error pulse, digits_seen[2] stays 0, no frame_valid until a valid hundreds digit arrives.
REQ-031 Anode 4'b0011 held stable -> one anode_error pulse and no capture; anode 4'b1111 held stable -> no error and no capture.
REQ-032 Frames 9999 then 0000 -> decoded_number = 16'h270F, then 16'h0000, one frame_valid per frame.
REQ-033 Reset after two digits are captured -> digits_seen = 0; a frame completes only after all four digits are re-captured.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan decoder: cathode patterns, anode codes,
// default settle time and the BCD-to-binary helper used when a frame completes.
package seven_seg_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 16;

    // Active-low cathodes, bit6 = segment a ... bit0 = segment g
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;

    localparam logic [3:0] ANODE_THOUSANDS = 4'b0111;
    localparam logic [3:0] ANODE_HUNDREDS  = 4'b1011;
    localparam logic [3:0] ANODE_TENS      = 4'b1101;
    localparam logic [3:0] ANODE_UNITS     = 4'b1110;
    localparam logic [3:0] ANODE_BLANK     = 4'b1111;

    typedef enum logic [1:0] {
        ANODE_KIND_BLANK,
        ANODE_KIND_SINGLE,
        ANODE_KIND_MULTI
    } anode_kind_t;

    function automatic anode_kind_t classify_anode(input logic [3:0] anode);
        if (anode == ANODE_BLANK) return ANODE_KIND_BLANK;
        if ($countones(anode) == 3) return ANODE_KIND_SINGLE;
        return ANODE_KIND_MULTI;
    endfunction

    function automatic logic [15:0] bcd_to_bin(input logic [15:0] bcd);
        logic [16:0] sum;
        sum = 17'(bcd[15:12]) * 17'd1000 + 17'(bcd[11:8]) * 17'd100
            + 17'(bcd[7:4]) * 17'd10 + 17'(bcd[3:0]);
        return sum[15:0];
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// Combinational map from an active-low cathode pattern to a decimal digit;
// valid drops for any pattern outside the ten digit shapes.
module seven_seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] cathode,
    output logic [3:0] digit,
    output logic       valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (cathode)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_display_decoder.sv
// Snoops a multiplexed 4-digit seven-segment drive, captures each digit once its
// anode/cathode pins settle, and publishes the value whenever all four digits are seen.
module seven_segment_display_decoder
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  Anode_Activate,
    input  logic [6:0]  LED_out,
    output logic [15:0] decoded_number,
    output logic [15:0] decoded_bcd,
    output logic        frame_valid,
    output logic        pattern_error,
    output logic        anode_error,
    output logic [3:0]  digits_seen
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [10:0]   sync_meta;
    logic [10:0]   sync_data;
    logic [CW-1:0] stable_count;
    logic          changed;
    logic          capture;
    logic [3:0]    anode;
    logic [6:0]    cathode;
    logic [3:0]    seg_digit;
    logic          seg_valid;
    anode_kind_t   anode_kind;
    logic          write_digit;
    logic [3:0]    position;
    logic [15:0]   digits;
    logic          frame_done;
    logic [3:0]    seen_next;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync_data <= '0;
        end else begin
            sync_meta <= {Anode_Activate, LED_out};
            sync_data <= sync_meta;
        end
    end

    // Comparing the two synchronizer stages flags the edge where the settled value moves,
    // which keeps pin-to-frame_valid latency at SETTLE_CYCLES+3.
    assign changed = (sync_meta != sync_data);

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            stable_count <= '0;
        end else if (changed) begin
            stable_count <= '0;
        end else if (stable_count != COUNT_MAX) begin
            stable_count <= stable_count + 1'b1;
        end
    end

    assign capture = !changed && (stable_count == COUNT_LAST);
    assign anode   = sync_data[10:7];
    assign cathode = sync_data[6:0];

    seven_seg_pattern_decoder u_pattern_decoder (
        .cathode (cathode),
        .digit   (seg_digit),
        .valid   (seg_valid)
    );

    assign anode_kind  = classify_anode(anode);
    assign write_digit = capture && (anode_kind == ANODE_KIND_SINGLE) && seg_valid;
    assign position    = ~anode;
    assign frame_done  = (digits_seen == 4'b1111);

    always_comb begin
        seen_next = frame_done ? 4'b0000 : digits_seen;
        if (write_digit) seen_next = seen_next | position;
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            digits_seen <= '0;
        end else begin
            digits_seen <= seen_next;
            if (write_digit) begin
                for (int i = 0; i < 4; i++) begin
                    if (position[i]) digits[4*i +: 4] <= seg_digit;
                end
            end
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            decoded_number <= '0;
            decoded_bcd    <= '0;
            frame_valid    <= 1'b0;
            pattern_error  <= 1'b0;
            anode_error    <= 1'b0;
        end else begin
            frame_valid   <= frame_done;
            pattern_error <= capture && (anode_kind == ANODE_KIND_SINGLE) && !seg_valid;
            anode_error   <= capture && (anode_kind == ANODE_KIND_MULTI);
            if (frame_done) begin
                decoded_bcd    <= digits;
                decoded_number <= bcd_to_bin(digits);
            end
        end
    end

endmodule
